// File: rtl/spi_slave_rx.sv
// SPI receive stage: oversamples sclk/cs/mosi on clk, deserializes LSB-first frames,
// and hands words out on a valid/ready port with overrun and short-frame pulses.
module spi_slave_rx #(
    parameter int DW         = 12,
    parameter int LEAD_EDGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          cs,
    input  logic          mosi,
    output logic [DW-1:0] dout,
    output logic          dvalid,
    input  logic          dready,
    output logic          overrun,
    output logic          frame_err
);

    localparam int MAXC = (DW > LEAD_EDGES) ? DW : LEAD_EDGES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, LEAD, SHIFT, WAIT_CS} state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [DW-1:0] shreg, shreg_n;
    logic          word_done, frame_err_n;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic cs_s1, cs_s2;
    logic mosi_s1, mosi_s2;
    logic fall_det;

    assign fall_det = !sclk_s2 && sclk_s3;

    always_comb begin
        state_n     = state;
        count_n     = count;
        shreg_n     = shreg;
        word_done   = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                count_n = '0;
                shreg_n = '0;
                if (!cs_s2) state_n = (LEAD_EDGES == 0) ? SHIFT : LEAD;
            end
            LEAD: begin
                if (cs_s2) begin
                    frame_err_n = 1'b1;
                    count_n     = '0;
                    state_n     = IDLE;
                end else if (fall_det) begin
                    if (32'(count) + 1 == LEAD_EDGES) begin
                        count_n = '0;
                        state_n = SHIFT;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cs_s2) begin
                    frame_err_n = 1'b1;
                    count_n     = '0;
                    shreg_n     = '0;
                    state_n     = IDLE;
                end else if (fall_det) begin
                    shreg_n[count] = mosi_s2;
                    if (32'(count) == DW - 1) begin
                        word_done = 1'b1;
                        count_n   = '0;
                        state_n   = WAIT_CS;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_s2) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_s3   <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            state     <= IDLE;
            count     <= '0;
            shreg     <= '0;
            dout      <= '0;
            dvalid    <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_s3   <= sclk_s2;
            cs_s1     <= cs;
            cs_s2     <= cs_s1;
            mosi_s1   <= mosi;
            mosi_s2   <= mosi_s1;
            state     <= state_n;
            count     <= count_n;
            shreg     <= shreg_n;
            frame_err <= frame_err_n;
            overrun   <= 1'b0;
            // A handshake in the completion cycle frees the register for the new word.
            if (word_done) begin
                if (!dvalid || dready) begin
                    dout   <= shreg_n;
                    dvalid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dvalid && dready) begin
                dvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives master-format frames, scoreboards words
// popped on handshakes and counts flag pulses.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b1;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        dready = 1'b0;
    logic [11:0] dout;
    logic        dvalid, overrun, frame_err;

    spi_slave_rx #(.DW(12), .LEAD_EDGES(1)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .dout(dout), .dvalid(dvalid), .dready(dready),
        .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          ovr_cnt = 0;
    int          ferr_cnt = 0;
    int          words = 0;
    logic [11:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every handshake, tallies flag pulses.
    always @(negedge clk) begin
        if (rst) begin
            if (overrun) ovr_cnt++;
            if (frame_err) ferr_cnt++;
            if (dvalid && dready) begin
                words++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", dout);
                end else begin
                    check("word", {20'h0, dout}, {20'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Frame as the master sends it: one lead falling edge, then LSB-first bits.
    // hs_last pulses dready so it is sampled in the cycle the last bit completes.
    task automatic send(input logic [11:0] w, input int nbits, input int extra, input bit hs_last);
        cs = 1'b0;
        wait_clks(6);
        sclk = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[i];
            sclk = 1'b1;
            wait_clks(6);
            sclk = 1'b0;
            if (hs_last && i == nbits - 1) begin
                wait_clks(2);
                dready = 1'b1;
                wait_clks(1);
                dready = 1'b0;
                wait_clks(3);
            end else begin
                wait_clks(6);
            end
        end
        for (int i = 0; i < extra; i++) begin
            sclk = 1'b1;
            wait_clks(6);
            sclk = 1'b0;
            wait_clks(6);
        end
        sclk = 1'b1;
        wait_clks(6);
        cs = 1'b1;
        wait_clks(8);
    endtask

    initial begin
        // Reset state
        wait_clks(4);
        check("rst_dout", {20'h0, dout}, 32'h0);
        check("rst_dvalid", {31'h0, dvalid}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);
        check("rst_frame_err", {31'h0, frame_err}, 32'h0);
        rst = 1'b1;
        wait_clks(4);

        // Single frame, consumer always ready
        dready = 1'b1;
        exp_q.push_back(12'hA5C);
        send(12'hA5C, 12, 0, 1'b0);
        wait_clks(4);
        check("t1_overrun_cnt", ovr_cnt, 0);
        check("t1_ferr_cnt", ferr_cnt, 0);
        check("t1_dvalid", {31'h0, dvalid}, 32'h0);

        // Back-to-back with stalled consumer: second word dropped
        dready = 1'b0;
        exp_q.push_back(12'h001);
        send(12'h001, 12, 0, 1'b0);
        send(12'h800, 12, 0, 1'b0);
        check("t2_dout", {20'h0, dout}, 32'h001);
        check("t2_dvalid", {31'h0, dvalid}, 32'h1);
        check("t2_overrun_cnt", ovr_cnt, 1);
        dready = 1'b1;
        wait_clks(3);
        check("t2_dvalid_after", {31'h0, dvalid}, 32'h0);

        // Short frame then a good one
        send(12'h0FF, 5, 0, 1'b0);
        check("t3_ferr_cnt", ferr_cnt, 1);
        check("t3_dvalid", {31'h0, dvalid}, 32'h0);
        exp_q.push_back(12'h3C3);
        send(12'h3C3, 12, 0, 1'b0);
        wait_clks(4);

        // Completion coincides with handshake of the previous word
        dready = 1'b0;
        exp_q.push_back(12'h111);
        exp_q.push_back(12'h222);
        send(12'h111, 12, 0, 1'b0);
        send(12'h222, 12, 0, 1'b1);
        check("t4_dout", {20'h0, dout}, 32'h222);
        check("t4_dvalid", {31'h0, dvalid}, 32'h1);
        check("t4_overrun_cnt", ovr_cnt, 1);
        dready = 1'b1;
        wait_clks(4);

        // Stray sclk with cs high, and extra edges after the last bit
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b0;
            wait_clks(6);
            sclk = 1'b1;
            wait_clks(6);
        end
        check("t5_words_idle", words, 5);
        exp_q.push_back(12'h456);
        send(12'h456, 12, 3, 1'b0);
        wait_clks(4);
        check("t5_words", words, 6);
        check("t5_ferr_cnt", ferr_cnt, 1);
        check("t5_overrun_cnt", ovr_cnt, 1);

        // Reset mid-frame after 6 bits
        cs = 1'b0;
        wait_clks(6);
        sclk = 1'b0;
        wait_clks(6);
        for (int i = 0; i < 6; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            wait_clks(6);
            sclk = 1'b0;
            wait_clks(6);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_clks(1);
            check("t6_rst_outs", {17'h0, dout, dvalid, overrun, frame_err}, 32'h0);
        end
        cs = 1'b1;
        sclk = 1'b1;
        wait_clks(4);
        rst = 1'b1;
        wait_clks(4);
        exp_q.push_back(12'hFFF);
        send(12'hFFF, 12, 0, 1'b0);
        wait_clks(10);

        check("final_words", words, 7);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_overrun_cnt", ovr_cnt, 1);
        check("final_ferr_cnt", ferr_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
